serial_subtractor: RTL and testbench



---
 rtl/serial_subtractor_if.sv | 45 ++++
 rtl/serial_subtractor.sv | 123 ++++++++++++
 tb/tb_serial_subtractor.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
//   Bundles the operand/result handshake of the bit-serial subtractor.
//
//   Handshake: the requester drives start with a/b valid; the subtractor
//   accepts on the first rising edge where it is idle and start=1. busy is
//   high for the WIDTH serial cycles, then done pulses for one cycle with
//   diff/borrow/overflow/zero valid. The results are held until the next
//   completion. start is ignored unless the subtractor is idle.
//
//   Signals:
//     start     requester -> subtractor  operation request
//     a, b      requester -> subtractor  minuend / subtrahend
//     busy      subtractor -> requester  serial operation in progress
//     done      subtractor -> requester  one-cycle completion pulse
//     diff      subtractor -> requester  a - b mod 2^WIDTH
//     borrow    subtractor -> requester  unsigned borrow (a < b)
//     overflow  subtractor -> requester  signed overflow of a - b
//     zero      subtractor -> requester  diff == 0
//     fsm_state subtractor -> requester  current FSM state (debug)
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow;
   logic             overflow;
   logic             zero;
   logic [1:0]       fsm_state;

   modport master (
      output start, a, b,
      input  busy, done, diff, borrow, overflow, zero, fsm_state
   );

   modport slave (
      input  start, a, b,
      output busy, done, diff, borrow, overflow, zero, fsm_state
   );
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
//   Bit-serial two's-complement subtractor: computes a - b LSB-first, one bit
//   per clock, through a single full-subtractor cell with a registered borrow.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     bus    serial_subtractor_if.slave (start/a/b in; busy/done/diff/
//            borrow/overflow/zero/fsm_state out)
//
//   Timing: start accepted at edge E0 -> busy for WIDTH cycles, done high
//   between E0+WIDTH and E0+WIDTH+1, earliest next acceptance at E0+WIDTH+2.
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   serial_subtractor_if.slave   bus
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic [WIDTH-1:0] sa, sb, sr;
   logic             br;
   logic [CW-1:0]    cnt;

   logic [WIDTH-1:0] diff_q;
   logic             borrow_q, overflow_q, zero_q;

   // full-subtractor cell on the current LSBs
   logic             x, y, d, bo;
   logic [WIDTH-1:0] sr_nxt;
   logic             last;

   assign x      = sa[0];
   assign y      = sb[0];
   assign d      = x ^ y ^ br;
   assign bo     = (~x & y) | (~(x ^ y) & br);
   assign sr_nxt = {d, sr[WIDTH-1:1]};
   assign last   = (cnt == CW'(WIDTH - 1));

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SHIFT;
         SHIFT:   if (last)      state_nxt = DONE;
         DONE:                   state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // ---------------- datapath ----------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sa         <= '0;
         sb         <= '0;
         sr         <= '0;
         br         <= 1'b0;
         cnt        <= '0;
         diff_q     <= '0;
         borrow_q   <= 1'b0;
         overflow_q <= 1'b0;
         zero_q     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sa  <= bus.a;
                  sb  <= bus.b;
                  sr  <= '0;
                  br  <= 1'b0;
                  cnt <= '0;
               end
            end
            SHIFT: begin
               sa  <= sa >> 1;
               sb  <= sb >> 1;
               sr  <= sr_nxt;
               br  <= bo;
               cnt <= cnt + CW'(1);
               if (last) begin
                  // br is the borrow into the MSB cell here, bo the borrow out
                  diff_q     <= sr_nxt;
                  borrow_q   <= bo;
                  overflow_q <= br ^ bo;
                  zero_q     <= (sr_nxt == '0);
               end
            end
            default: ;
         endcase
      end
   end

   // ---------------- outputs (registered state only) ----------------
   assign bus.busy      = (state == SHIFT);
   assign bus.done      = (state == DONE);
   assign bus.diff      = diff_q;
   assign bus.borrow    = borrow_q;
   assign bus.overflow  = overflow_q;
   assign bus.zero      = zero_q;
   assign bus.fsm_state = state;

endmodule

// File: tb/tb_serial_subtractor.sv
// -----------------------------------------------------------------------------
// tb_serial_subtractor
//   Self-checking bench for serial_subtractor (WIDTH=8). Expected results come
//   from plain arithmetic on the operands; handshake timing is checked against
//   the documented cycle counts.
// -----------------------------------------------------------------------------
module tb_serial_subtractor;

   localparam int W = 8;

   logic clk;
   logic rst_n;
   int   n_vec = 0;
   int   n_err = 0;
   int   cyc   = 0;

   // expected {borrow, overflow, zero, diff}
   logic [W+2:0] exp_q[$];

   serial_subtractor_if #(.WIDTH(W)) bus ();

   serial_subtractor #(.WIDTH(W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   function automatic logic [W+2:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [W-1:0] d;
      logic         bw, ov, zr;
      d  = x - y;
      bw = (x < y);
      ov = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]);
      zr = (d == '0);
      return {bw, ov, zr, d};
   endfunction

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_vec++;
      if (obs !== exp_v) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic check_result(input string tag, input logic [W+2:0] e);
      check({tag, "_diff"},     32'(bus.diff),     32'(e[W-1:0]));
      check({tag, "_zero"},     32'(bus.zero),     32'(e[W]));
      check({tag, "_overflow"}, 32'(bus.overflow), 32'(e[W+1]));
      check({tag, "_borrow"},   32'(bus.borrow),   32'(e[W+2]));
   endtask

   task automatic check_outputs_reset(input string tag);
      check({tag, "_busy"}, 32'(bus.busy), 32'd0);
      check({tag, "_done"}, 32'(bus.done), 32'd0);
      check_result(tag, '0);
   endtask

   // wait at negedges until done, counting busy cycles; bounded
   task automatic wait_done(input string tag, output int bcnt);
      int guard;
      bcnt  = 0;
      guard = 0;
      while (!bus.done && guard < 40) begin
         if (bus.busy) bcnt++;
         @(negedge clk);
         guard++;
      end
      check({tag, "_done_seen"}, 32'(bus.done), 32'd1);
      check({tag, "_busy_excl"}, 32'(bus.busy), 32'd0);
   endtask

   // ---------------- driver ----------------
   task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
      int bcnt;
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = ta;
      bus.b     = tb_v;
      exp_q.push_back(model(ta, tb_v));
      @(negedge clk);
      bus.start = 1'b0;
      bus.a     = W'($urandom);
      bus.b     = W'($urandom);
      wait_done(tag, bcnt);
      check({tag, "_busy_len"}, 32'(bcnt), 32'(W));
      check_result(tag, exp_q.pop_front());
      @(negedge clk);
      check({tag, "_done_pulse"}, 32'(bus.done), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin : main
      logic [W+2:0] e;
      int bcnt;
      int t_done[3];
      int nd;
      int seen_done;

      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;

      #3;
      check_outputs_reset("reset");
      check("reset_state", 32'(bus.fsm_state), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // directed cases
      run_op(8'h05, 8'h03, "basic");
      run_op(8'h03, 8'h05, "borrow");
      run_op(8'h80, 8'h01, "ovf_pos");
      run_op(8'h7F, 8'hFF, "ovf_neg");
      run_op(8'h5A, 8'h5A, "zero");

      // hold through 20 idle cycles
      e = model(8'h5A, 8'h5A);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check_result("hold", e);
         check("hold_busy", 32'(bus.busy), 32'd0);
      end

      // start pulses during busy and done are ignored
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h10;
      bus.b     = 8'h01;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'hFF;
      bus.b     = 8'h00;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done("ign", bcnt);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check_result("ign", model(8'h10, 8'h01));
      repeat (3) @(negedge clk);
      check("ign_no_restart", 32'(bus.busy), 32'd0);
      check_result("ign_after", model(8'h10, 8'h01));

      // continuous start: done pulses exactly WIDTH+2 apart
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'h33;
      bus.b     = 8'h11;
      nd = 0;
      for (int i = 0; i < 60 && nd < 3; i++) begin
         @(negedge clk);
         if (bus.done) begin
            t_done[nd] = cyc;
            nd++;
         end
      end
      bus.start = 1'b0;
      check("cont_pulses", 32'(nd), 32'd3);
      if (nd == 3) begin
         check("cont_gap1", 32'(t_done[1] - t_done[0]), 32'(W + 2));
         check("cont_gap2", 32'(t_done[2] - t_done[1]), 32'(W + 2));
      end
      check_result("cont", model(8'h33, 8'h11));
      // drain the operation accepted on the last DONE->IDLE cycle, if any
      repeat (W + 4) @(negedge clk);

      // reset mid-operation on the 4th busy cycle
      @(negedge clk);
      bus.start = 1'b1;
      bus.a     = 8'hC3;
      bus.b     = 8'h21;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_mid_busy_before", 32'(bus.busy), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_outputs_reset("rst_mid");
      @(negedge clk);
      rst_n = 1'b1;
      seen_done = 0;
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         if (bus.done || bus.busy) seen_done++;
      end
      check("rst_mid_no_done", 32'(seen_done), 32'd0);
      run_op(8'h09, 8'h04, "after_rst");

      // randomized operands
      for (int i = 0; i < 30; i++) begin
         run_op(W'($urandom_range(0, 255)), W'($urandom_range(0, 255)), "rand");
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // global watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
      $fatal(1, "timeout");
   end

endmodule
